// File: rtl/xbox_mem_pkg.sv
// Shared types and helpers for the XBOX accelerator memory bank responder.
package xbox_mem_pkg;

   localparam int unsigned LINE_WORDS     = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTES_PER_LINE = 32;
   localparam int unsigned LINE_BITS      = LINE_WORDS * WORD_W;

   typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;
   typedef logic [BYTES_PER_LINE-1:0]         be_t;

   // Per-instance port owner, derived combinationally every cycle
   typedef enum logic [1:0] {
      BANK_IDLE    = 2'd0,
      BANK_XLR_ACT = 2'd1,
      BANK_HST_ACT = 2'd2
   } bank_state_e;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Byte i of the flattened line is byte i%4 of word i/4
   function automatic line_t apply_be(input line_t old_line, input line_t new_line, input be_t be);
      logic [LINE_BITS-1:0] res;
      logic [LINE_BITS-1:0] nw;
      res = old_line;
      nw  = new_line;
      for (int unsigned i = 0; i < BYTES_PER_LINE; i++) begin
         if (be[i]) res[i*8 +: 8] = nw[i*8 +: 8];
      end
      return line_t'(res);
   endfunction

endpackage

// File: rtl/xbox_mem_bank_resp_if.sv
// Accelerator and host request/response bundle of the XBOX memory bank responder.
interface xbox_mem_bank_resp_if
   import xbox_mem_pkg::*;
#(
   parameter int unsigned NUM_MEMS           = 2,
   parameter int unsigned LOG2_LINES_PER_MEM = 8
);
   localparam int unsigned MEM_IDX_W = idx_w(NUM_MEMS);

   logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr;
   line_t [NUM_MEMS-1:0]                        xlr_mem_wdata;
   be_t   [NUM_MEMS-1:0]                        xlr_mem_be;
   logic  [NUM_MEMS-1:0]                        xlr_mem_rd;
   logic  [NUM_MEMS-1:0]                        xlr_mem_wr;
   line_t [NUM_MEMS-1:0]                        xlr_mem_rdata;

   logic                          hst_req_valid;
   logic                          hst_req_ready;
   logic [MEM_IDX_W-1:0]          hst_req_mem;
   logic [LOG2_LINES_PER_MEM-1:0] hst_req_addr;
   logic                          hst_req_wr;
   line_t                         hst_req_wdata;
   be_t                           hst_req_be;
   logic                          hst_rsp_valid;
   line_t                         hst_rsp_rdata;

   logic [NUM_MEMS-1:0]           mem_err;

   modport master (
      output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
      output hst_req_valid, hst_req_mem, hst_req_addr, hst_req_wr, hst_req_wdata, hst_req_be,
      input  xlr_mem_rdata, hst_req_ready, hst_rsp_valid, hst_rsp_rdata, mem_err
   );

   modport slave (
      input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
      input  hst_req_valid, hst_req_mem, hst_req_addr, hst_req_wr, hst_req_wdata, hst_req_be,
      output xlr_mem_rdata, hst_req_ready, hst_rsp_valid, hst_rsp_rdata, mem_err
   );

endinterface

// File: rtl/xbox_mem_inst.sv
// One line-organised memory instance: array, accelerator read register and port mux.
// Collision flag logic is built only when XBOX_MEM_COLLISION_CHK_EN is defined.
module xbox_mem_inst
   import xbox_mem_pkg::*;
#(
   parameter int unsigned LOG2_LINES_PER_MEM = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [LOG2_LINES_PER_MEM-1:0] xlr_addr_i,
   input  line_t                         xlr_wdata_i,
   input  be_t                           xlr_be_i,
   input  logic                          xlr_rd_i,
   input  logic                          xlr_wr_i,
   input  logic                          hst_sel_i,
   input  logic [LOG2_LINES_PER_MEM-1:0] hst_addr_i,
   input  line_t                         hst_wdata_i,
   input  be_t                           hst_be_i,
   input  logic                          hst_wr_i,
   output line_t                         xlr_rdata_o,
   output line_t                         hst_rdata_c_o,
   output logic                          mem_err_o
);

   localparam int unsigned LINES = 2 ** LOG2_LINES_PER_MEM;

   line_t                         mem_q [LINES];
   line_t                         rdata_d;
   line_t                         rdata_q;
   bank_state_e                   state_c;
   logic                          we_c;
   logic [LOG2_LINES_PER_MEM-1:0] waddr_c;
   line_t                         wdata_c;
   be_t                           wbe_c;

   // Accelerator always owns the port when it strobes
   always_comb begin
      state_c = BANK_IDLE;
      if (xlr_rd_i || xlr_wr_i) state_c = BANK_XLR_ACT;
      else if (hst_sel_i)       state_c = BANK_HST_ACT;
   end

   always_comb begin
      we_c    = 1'b0;
      waddr_c = '0;
      wdata_c = '0;
      wbe_c   = '0;
      rdata_d = rdata_q;
      unique case (state_c)
         BANK_XLR_ACT: begin
            we_c    = xlr_wr_i;
            waddr_c = xlr_addr_i;
            wdata_c = xlr_wdata_i;
            wbe_c   = xlr_be_i;
            if (!xlr_wr_i) rdata_d = mem_q[xlr_addr_i];
         end
         BANK_HST_ACT: begin
            we_c    = hst_wr_i;
            waddr_c = hst_addr_i;
            wdata_c = hst_wdata_i;
            wbe_c   = hst_be_i;
         end
         default: ;
      endcase
   end

   // Array is never reset; writes sampled during reset are dropped
   always_ff @(posedge clk) begin
      if (rst_n && we_c) mem_q[waddr_c] <= apply_be(mem_q[waddr_c], wdata_c, wbe_c);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign xlr_rdata_o   = rdata_q;
   assign hst_rdata_c_o = mem_q[hst_addr_i];

`ifdef XBOX_MEM_COLLISION_CHK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (xlr_rd_i && xlr_wr_i) begin
         err_q <= 1'b1;
         $error("%m: xlr rd/wr collision at line %0d", xlr_addr_i);
      end
   end

   assign mem_err_o = err_q;
`else
   assign mem_err_o = 1'b0;
`endif

endmodule

// File: rtl/xbox_mem_bank_resp.sv
// XBOX memory bank responder top: host decode/arbitration, host response register, instances.
// Optional rd/wr collision flagging via XBOX_MEM_COLLISION_CHK_EN.
module xbox_mem_bank_resp
   import xbox_mem_pkg::*;
#(
   parameter int unsigned NUM_MEMS           = 2,
   parameter int unsigned LOG2_LINES_PER_MEM = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   xbox_mem_bank_resp_if.slave  bus
);

   localparam int unsigned MEM_IDX_W = idx_w(NUM_MEMS);

   logic                 hst_ready_c;
   logic                 hst_acc_c;
   logic [NUM_MEMS-1:0]  hst_sel_c;
   line_t                hst_line_c;
   line_t [NUM_MEMS-1:0] inst_line_c;
   logic [NUM_MEMS-1:0]  err_c;
   logic                 rsp_valid_d;
   logic                 rsp_valid_q;
   line_t                rsp_rdata_d;
   line_t                rsp_rdata_q;

   // Host stalls only while the accelerator strobes the targeted instance
   always_comb begin
      hst_ready_c = 1'b1;
      hst_line_c  = '0;
      for (int unsigned m = 0; m < NUM_MEMS; m++) begin
         if (bus.hst_req_mem == MEM_IDX_W'(m)) begin
            hst_ready_c = !(bus.xlr_mem_rd[m] || bus.xlr_mem_wr[m]);
            hst_line_c  = inst_line_c[m];
         end
      end
   end

   assign hst_acc_c         = bus.hst_req_valid && hst_ready_c;
   assign bus.hst_req_ready = hst_ready_c;

   always_comb begin
      hst_sel_c = '0;
      for (int unsigned m = 0; m < NUM_MEMS; m++) begin
         hst_sel_c[m] = hst_acc_c && (bus.hst_req_mem == MEM_IDX_W'(m));
      end
   end

   always_comb begin
      rsp_valid_d = hst_acc_c && !bus.hst_req_wr;
      rsp_rdata_d = rsp_rdata_q;
      if (rsp_valid_d) rsp_rdata_d = hst_line_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.hst_rsp_valid = rsp_valid_q;
   assign bus.hst_rsp_rdata = rsp_rdata_q;
   assign bus.mem_err       = err_c;

   for (genvar g = 0; g < NUM_MEMS; g++) begin : g_mem
      xbox_mem_inst #(
         .LOG2_LINES_PER_MEM (LOG2_LINES_PER_MEM)
      ) u_inst (
         .clk           (clk),
         .rst_n         (rst_n),
         .xlr_addr_i    (bus.xlr_mem_addr[g]),
         .xlr_wdata_i   (bus.xlr_mem_wdata[g]),
         .xlr_be_i      (bus.xlr_mem_be[g]),
         .xlr_rd_i      (bus.xlr_mem_rd[g]),
         .xlr_wr_i      (bus.xlr_mem_wr[g]),
         .hst_sel_i     (hst_sel_c[g]),
         .hst_addr_i    (bus.hst_req_addr),
         .hst_wdata_i   (bus.hst_req_wdata),
         .hst_be_i      (bus.hst_req_be),
         .hst_wr_i      (bus.hst_req_wr),
         .xlr_rdata_o   (bus.xlr_mem_rdata[g]),
         .hst_rdata_c_o (inst_line_c[g]),
         .mem_err_o     (err_c[g])
      );
   end

endmodule

// File: doc/xbox_mem_bank_resp.md
# xbox_mem_bank_resp

Responder end of the XBOX accelerator memory interface: holds NUM_MEMS line-organised memory instances of 256-bit lines and services the accelerator's per-instance addr/rd/wr/be/wdata requests with registered read data. A secondary host port with a valid/ready handshake loads operands and collects results. The accelerator always has priority on an instance; host requests to that instance stall. Sits between the accelerator and the XBOX fabric, and is the memory model the accelerator bench binds to.

## Interface
- NUM_MEMS, 2, number of memory instances
- LOG2_LINES_PER_MEM, 8, address width; each instance holds 2^LOG2_LINES_PER_MEM lines of 8x32 bits
- clk  in  1  system clock; the block has one clock domain
- rst_n  in  1  reset, synchronous, active-low
- xlr_mem_addr  in  [NUM_MEMS][LOG2_LINES_PER_MEM]  line address per instance
- xlr_mem_wdata  in  [NUM_MEMS][8][32]  write line per instance
- xlr_mem_be  in  [NUM_MEMS][32]  byte enables; bit i enables byte i%4 of word i/4
- xlr_mem_rd  in  [NUM_MEMS]  read strobe
- xlr_mem_wr  in  [NUM_MEMS]  write strobe
- xlr_mem_rdata  out  [NUM_MEMS][8][32]  registered read line
- hst_req_valid  in  1  host request valid
- hst_req_ready  out  1  host request accepted this cycle when high together with valid
- hst_req_mem  in  $clog2(NUM_MEMS)  target instance
- hst_req_addr  in  LOG2_LINES_PER_MEM  line address
- hst_req_wr  in  1  1 = write, 0 = read
- hst_req_wdata  in  [8][32]  write line
- hst_req_be  in  32  byte enables
- hst_rsp_valid  out  1  single-cycle pulse, read data valid
- hst_rsp_rdata  out  [8][32]  host read line
- mem_err  out  [NUM_MEMS]  sticky rd/wr collision flag (see Configuration)

## Operation
- Accelerator read: when xlr_mem_rd[m] is high at edge N, xlr_mem_rdata[m] shows line[addr] after edge N.
  - rdata holds its value until the next read of that instance.
- Accelerator write: when xlr_mem_wr[m] is high at edge N, each byte with a set be bit is written at edge N. Bytes with a clear be bit keep their value.
  - be = 0 writes nothing.
- xlr rd and wr high together on one instance: the write is performed and the read is ignored. rdata holds its previous value.
- Read-after-write to the same address on the next cycle returns the new data. There is no bypass within a single cycle.
- Host port, combinational:
  - hst_req_ready = !(xlr_mem_rd[hst_req_mem] | xlr_mem_wr[hst_req_mem]).
  - Accepted on valid & ready.
  - The host must hold valid and all payload stable until accepted.
- Host write: applied at the acceptance edge with the same be rules as the accelerator.
- Host read: hst_rsp_valid pulses for one cycle after the acceptance edge, with hst_rsp_rdata = line at acceptance time.
  - hst_rsp_rdata holds until the next host read.
  - There is no response backpressure.
  - A new request may be accepted every cycle.
- Accelerator traffic on instance m never stalls host access to instance k≠m.
- Host read/write on the same instance as an accelerator access in the same cycle is impossible by construction, because ready is low.
- State per instance: IDLE / XLR_ACT / HST_ACT, derived each cycle. Only the rdata and response registers carry state across cycles, besides the array.

## Timing
- Read latency 1 cycle for both ports. Write takes effect at the strobe edge.
- Reset values (rst_n low at an edge):
  - xlr_mem_rdata = 0
  - hst_rsp_valid = 0
  - hst_rsp_rdata = 0
  - mem_err = 0
- The memory array is never reset. Contents survive rst_n.
- Reset asserted mid-transaction: strobes sampled with rst_n low are discarded, including writes. A pending hst_rsp_valid is cleared.
- hst_req_ready has no reset dependence. It is valid in every cycle as a function of the current xlr strobes.

## Configuration
- XBOX_MEM_COLLISION_CHK_EN defined:
  - mem_err[m] is set at the edge where xlr_mem_rd[m] & xlr_mem_wr[m].
  - It stays set until rst_n.
  - A simulation $error is issued with the instance and address.
- XBOX_MEM_COLLISION_CHK_EN undefined: mem_err is tied to 0 and no check logic is generated. The write-wins behaviour is unchanged.

## Structure
- Package xbox_mem_pkg:
  - line_t (logic [7:0][31:0])
  - be_t (logic [31:0])
  - LINE_WORDS = 8
  - BYTES_PER_LINE = 32
  - byte-merge function apply_be(old, new, be)
- Sub-module xbox_mem_inst: one instance of the array, read register and port mux. It is generated NUM_MEMS times.
- The top level holds host arbitration, host response register and the hst_req_mem decode.

## Test plan
- Host write mem0 addr 0 with words 1,2,3,4,5,6,7,8 and be=FFFFFFFF; xlr rd mem0 addr 0 → xlr_mem_rdata[0] = {1..8} one cycle later.
- xlr wr mem1 addr 1, wdata all 0xAAAAAAAA, be=0000000F; then xlr rd mem1 addr 1 → word0 = AAAAAAAA, words 1–7 unchanged from the prior host fill.
- Host read mem0 addr 5 while xlr_mem_rd[0] is high for 3 cycles → ready low for 3 cycles; accepted in cycle 4; rsp_valid pulses in cycle 5 with correct data. The same request to mem1 is accepted immediately.
- xlr rd and wr to mem0 addr 2 in the same cycle → line written, rdata unchanged; mem_err[0]=1 only with XBOX_MEM_COLLISION_CHK_EN.
- Write mem0 addr 3 = 0x12345678…; assert rst_n low for 2 cycles → rdata, rsp and mem_err are 0; a subsequent read of addr 3 still returns 0x12345678….
- 2x2 MatMul flow with the accelerator: host loads A={1,2,3,4}, B={5,6,7,8} at addr 0; after DONE, host read of mem0 addr 1 → {19,22,43,50,0,0,0,0}.
